// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// The result, carry-out and signed overflow are published in a single completion cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  res_reg;
    logic [WIDTH-1:0]  res_next;
    logic              carry_reg;
    logic              carry_next;
    logic              bit_sum;
    logic [IDX_W-1:0]  idx_reg;

    // The operands shift right each step, so bit 0 always holds the bit being added.
    assign bit_sum    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

    always_comb begin
        res_next            = res_reg >> 1;
        res_next[WIDTH-1]   = bit_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1.
                        a_reg     <= a;
                        b_reg     <= b ^ {WIDTH{sub}};
                        carry_reg <= sub | cin;
                        idx_reg   <= '0;
                        res_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= carry_next;
                    res_reg   <= res_next;
                    idx_reg   <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        sum       <= res_next;
                        cout      <= carry_next;
                        ovf       <= carry_reg ^ carry_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance plus a 1-bit instance,
// checked against plain-arithmetic expectations.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       sub = 1'b0, cin = 1'b0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start_w1 = 1'b0;
    logic [0:0] a_w1 = '0, b_w1 = '0;
    logic       sub_w1 = 1'b0, cin_w1 = 1'b0;
    logic       busy_w1, done_w1, cout_w1, ovf_w1;
    logic [0:0] sum_w1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w1), .a(a_w1), .b(b_w1), .sub(sub_w1), .cin(cin_w1),
        .busy(busy_w1), .done(done_w1), .sum(sum_w1), .cout(cout_w1), .ovf(ovf_w1)
    );

    // Reference: {ovf, cout, sum} from integer arithmetic and operand signs.
    function automatic logic [9:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic msub, input logic mcin);
        int          full;
        logic [7:0]  beff;
        logic [7:0]  s;
        logic        o;
        beff = msub ? ~mb : mb;
        full = int'(ma) + int'(beff) + (msub ? 1 : int'(mcin));
        s    = full[7:0];
        o    = (ma[7] == beff[7]) && (s[7] != ma[7]);
        return {o, full[8], s};
    endfunction

    // Drives one operation and records what was observed over a 12-cycle window.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                          input logic icin, input bit repulse,
                          output logic [7:0] osum, output logic ocout, output logic oovf,
                          output int olat, output int obusy, output int odone, output bit ostable);
        logic [7:0] s0;
        osum = 'x; ocout = 1'bx; oovf = 1'bx;
        olat = -1; obusy = 0; odone = 0; ostable = 1'b1;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; sub = isub; cin = icin;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
        sub = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
        s0 = sum;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (busy) obusy++;
            if (done) begin
                odone++;
                if (olat < 0) begin
                    olat = cyc; osum = sum; ocout = cout; oovf = ovf;
                end
            end else if (olat < 0 && sum !== s0) begin
                ostable = 1'b0;
            end
            if (repulse && cyc == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, ovf, sum} !== 12'h000) begin
            failures++;
            $display("FAIL reset_w8: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     busy, done, cout, ovf, sum);
        end
        checks++;
        if ({busy_w1, done_w1, cout_w1, ovf_w1, sum_w1} !== 5'h00) begin
            failures++;
            $display("FAIL reset_w1: got busy=%b done=%b cout=%b ovf=%b sum=%b, want all 0",
                     busy_w1, done_w1, cout_w1, ovf_w1, sum_w1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta[6] = '{8'h0F, 8'hFF, 8'h7F, 8'h00, 8'h05, 8'h80};
        logic [7:0] tb[6] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h07, 8'h01};
        logic       ts[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       tc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0] te[6] = '{{2'b00, 8'h10}, {2'b01, 8'h00}, {2'b10, 8'h80},
                              {2'b00, 8'h01}, {2'b00, 8'hFE}, {2'b11, 8'h7F}};
        logic [7:0] rs; logic rc, ro; int lat, bc, dc; bit st;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], ts[i], tc[i], 1'b0, rs, rc, ro, lat, bc, dc, st);
            $display("directed %0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b lat=%0d busy=%0d",
                     i, ta[i], tb[i], ts[i], tc[i], rs, rc, ro, lat, bc);
            checks++;
            if ({ro, rc, rs} !== te[i]) begin
                failures++;
                $display("FAIL directed_%0d: got ovf,cout,sum=%b,%b,%h want %b,%b,%h",
                         i, ro, rc, rs, te[i][9], te[i][8], te[i][7:0]);
            end
            checks++;
            if (lat != 8 || bc != 8 || dc != 1 || !st) begin
                failures++;
                $display("FAIL directed_timing_%0d: got lat=%0d busy=%0d dones=%0d stable=%b want 8,8,1,1",
                         i, lat, bc, dc, st);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, rs; logic rsub, rcin, rc, ro; logic [9:0] exp;
        int lat, bc, dc; bit st;
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255));
            rsub = 1'($urandom_range(1)); rcin = 1'($urandom_range(1));
            exp = model8(ra, rb, rsub, rcin);
            run_op(ra, rb, rsub, rcin, 1'b0, rs, rc, ro, lat, bc, dc, st);
            $display("random %0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     i, ra, rb, rsub, rcin, rs, rc, ro, lat);
            checks++;
            if ({ro, rc, rs} !== exp || lat != 8 || dc != 1 || !st) begin
                failures++;
                $display("FAIL random_%0d: got ovf,cout,sum=%b,%b,%h lat=%0d dones=%0d stable=%b want %b,%b,%h lat=8 dones=1 stable=1",
                         i, ro, rc, rs, lat, dc, st, exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_repulse();
        logic [7:0] rs; logic rc, ro; int lat, bc, dc; bit st;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat, bc, dc, st);
        $display("repulse: sum=%h cout=%b lat=%0d dones=%0d stable=%b", rs, rc, lat, dc, st);
        checks++;
        if (rs !== 8'h46 || rc !== 1'b0 || dc != 1 || !st || lat != 8) begin
            failures++;
            $display("FAIL repulse: got sum=%h cout=%b dones=%0d stable=%b lat=%0d want 46,0,1,1,8",
                     rs, rc, dc, st, lat);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        start = 1'b1; a = 8'h21; b = 8'h03; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!done && cyc < 12) begin
            @(negedge clk); cyc++;
        end
        // start stays high: ignored in DONE, accepted in the following IDLE cycle.
        a = 8'h40; b = 8'h02; sub = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_ignore: got busy=%b done=%b want 0,0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        cyc = 0;
        while (!done && cyc < 12) begin
            @(negedge clk); cyc++;
        end
        $display("back_to_back: sum=%h cout=%b lat=%0d", sum, cout, cyc);
        checks++;
        if (sum !== 8'h3E || cout !== 1'b1 || cyc != 8) begin
            failures++;
            $display("FAIL b2b_result: got sum=%h cout=%b lat=%0d want 3e,1,8", sum, cout, cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] rs; logic rc, ro; int lat, bc, dc, seen; bit st;
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, ovf, sum} !== 12'h000) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                     busy, done, cout, ovf, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || sum !== 8'h00) begin
            failures++;
            $display("FAIL midrun_abort: got %0d busy/done cycles sum=%h want 0, 00", seen, sum);
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, bc, dc, st);
        $display("after_reset: sum=%h lat=%0d", rs, lat);
        checks++;
        if (rs !== 8'h02 || lat != 8 || dc != 1) begin
            failures++;
            $display("FAIL after_reset: got sum=%h lat=%0d dones=%0d want 02,8,1", rs, lat, dc);
        end
    endtask

    task automatic test_width1();
        int cyc; logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_w1 = 1'b1; a_w1 = 1'(i >> 1); b_w1 = 1'(i); cin_w1 = 1'b0; sub_w1 = 1'b0;
            @(negedge clk);
            start_w1 = 1'b0;
            checks++;
            if (busy_w1 !== 1'b1) begin
                failures++;
                $display("FAIL w1_busy_%0d: got %b want 1", i, busy_w1);
            end
            cyc = 0;
            while (!done_w1 && cyc < 6) begin
                @(negedge clk); cyc++;
            end
            exp = 2'((i >> 1) + (i & 1));
            $display("width1 %0d: a=%b b=%b -> sum=%b cout=%b lat=%0d", i, a_w1, b_w1, sum_w1, cout_w1, cyc);
            checks++;
            if ({cout_w1, sum_w1} !== exp || cyc != 1) begin
                failures++;
                $display("FAIL w1_%0d: got cout,sum=%b,%b lat=%0d want %b,%b lat=1",
                         i, cout_w1, sum_w1, cyc, exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_repulse();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
